capture_event_fifo: RTL and testbench
=====================================

Name: capture_event_fifo

Overview:
- Sits directly downstream of the pin-capture stage.
- Consumes its 16-bit `data` sample and 1-cycle `event_detected` pulse.
- Tags each event with a cycle delta since the previous record and buffers the records in a FIFO.
- The host-readout stage drains the FIFO over a valid/ready interface.

Parameters:
- TS_W, 16: width of the delta-timestamp counter.
- DEPTH, 16: FIFO depth in records; power of 2, minimum 2.
- DATA_W, 16: captured pin-word width.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- arm_start  in  1  pulse; enter ARMED, clear delta counter.
- arm_stop  in  1  pulse; return to IDLE.
- flush  in  1  pulse; empty FIFO and clear overflow.
- cap_data  in  DATA_W  pin word from capture stage.
- cap_event  in  1  1-cycle event pulse from capture stage.
- out_valid  out  1  head record available.
- out_ready  in  1  consumer accepts head record.
- out_rec  out  1+TS_W+DATA_W  {timeout_flag, delta, data}.
- level  out  $clog2(DEPTH)+1  records currently stored.
- armed  out  1  state == ARMED.
- overflow  out  1  sticky; at least one record was dropped.

Behaviour:
- Reset (rst=1 at a posedge): state=IDLE, delta=0, FIFO empty, out_valid=0, out_rec=0, level=0, armed=0, overflow=0. rst overrides all other inputs.
- States:
  - IDLE: no records written, delta held at 0.
  - IDLE -> ARMED on arm_start.
  - ARMED -> IDLE on arm_stop.
  - arm_start and arm_stop in the same cycle: arm_stop wins (stays or becomes IDLE).
  - Entering ARMED clears delta to 0.
- Delta counter (ARMED only): increments by 1 each cycle; cleared to 0 in any cycle a record is generated, whether written or dropped.
- Event record: in ARMED, cap_event=1 generates {0, delta, cap_data}, using the pre-clear delta. Written at the next posedge.
- Timeout record: in ARMED with cap_event=0 and delta == 2^TS_W-1, generate {1, 2^TS_W-1, cap_data}. The delta never wraps silently.
- Event and timeout condition in the same cycle: only the event record is generated (flag 0, delta = max).
- Write acceptance: accepted iff level < DEPTH, evaluated on the registered level. A simultaneous read in a full cycle does not free a slot for that cycle's write.
- Rejected write: record dropped, overflow <= 1, delta still clears.
- Read:
  - Pop on out_valid && out_ready.
  - out_rec shows the head record combinationally from FIFO storage; first-word fall-through.
  - out_valid = (level != 0).
  - out_rec is undefined (don't-care) when out_valid=0; bench must not check it.
- Latency: cap_event at cycle N -> out_valid=1 at cycle N+1 if the FIFO was empty.
- Simultaneous push and pop (not full): level unchanged, ordering preserved.
- Pointers: DEPTH is a power of 2; pointers wrap naturally; level carries one extra bit to distinguish full from empty.
- flush:
  - Pointers and level -> 0, overflow -> 0.
  - A same-cycle write is discarded and a same-cycle pop is ignored.
  - State and delta are unaffected.
- arm_stop does not clear FIFO contents; the host drains them afterwards.
- Reset mid-operation: all records discarded; out_valid falls at the next posedge.

Decomposition:
- Shared package `capture_pkg` holds:
  - DATA_W and TS_W defaults.
  - REC_W = 1+TS_W+DATA_W.
  - Record field offsets: FLAG_BIT, DELTA_LSB, DATA_LSB.
  - State encoding: ST_IDLE, ST_ARMED.
- One sub-module, `sync_fifo`: parameterised WIDTH/DEPTH, first-word fall-through, push/pop/flush, full/empty/level, synchronous active-high reset.
- Top level holds the FSM, delta counter, record formation, accept/drop logic and the overflow flag.

Test Plan:
- Reset then arm_start; cap_event with cap_data=16'hA5A5 three cycles later -> first record {0, 3, A5A5}; out_valid high one cycle after the event; level=1.
- Two events 10 cycles apart, out_ready=1 -> records {0,d0,x} then {0,10,y}, in order; level returns to 0.
- TS_W=4, no events for 15 cycles after arm -> timeout record {1, 15, cap_data}, delta restarts; an event exactly at delta=15 gives flag 0, delta 15, and no timeout record.
- out_ready=0, 17 events with DEPTH=16 -> level=16, overflow=1, 17th dropped. Draining yields the first 16 in order. flush clears overflow and sets level=0.
- Full FIFO, event and pop in the same cycle -> pop occurs, event dropped, level=15, overflow=1.
- arm_start and arm_stop together -> armed=0, subsequent events produce no records. rst asserted with 5 records queued -> level=0, out_valid=0 next cycle.

Source files
------------

// File: rtl/capture_pkg.sv
// Shared types and record layout for the capture event FIFO.
// A record is {timeout_flag, delta, data} with data in the low bits.
package capture_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TS_W_DEF   = 16;
    localparam int REC_W_DEF  = 1 + TS_W_DEF + DATA_W_DEF;

    // Field offsets for the default widths.
    localparam int DATA_LSB  = 0;
    localparam int DELTA_LSB = DATA_W_DEF;
    localparam int FLAG_BIT  = DATA_W_DEF + TS_W_DEF;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    function automatic int rec_width(input int ts_w, input int data_w);
        return 1 + ts_w + data_w;
    endfunction

    function automatic int delta_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int flag_bit(input int ts_w, input int data_w);
        return data_w + ts_w;
    endfunction

endpackage

// File: rtl/capture_event_fifo_if.sv
// Capture-side input and host-readout side of the event FIFO.
interface capture_event_fifo_if #(
    parameter int DATA_W = 16,
    parameter int TS_W   = 16,
    parameter int DEPTH  = 16
) ();
    logic [DATA_W-1:0]        cap_data;
    logic                     cap_event;
    logic                     out_valid;
    logic                     out_ready;
    logic [TS_W+DATA_W:0]     out_rec;
    logic [$clog2(DEPTH):0]   level;

    // Environment side: capture stage plus host reader.
    modport master (
        output cap_data, cap_event, out_ready,
        input  out_valid, out_rec, level
    );

    // FIFO block side.
    modport slave (
        input  cap_data, cap_event, out_ready,
        output out_valid, out_rec, level
    );
endinterface

// File: rtl/capture_event_fifo_sync_fifo.sv
// First-word fall-through FIFO; the head entry is visible on rd_data
// without a pop. Count carries one extra bit so full and empty differ.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    input  logic                     flush,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == CNT_FULL);
    assign empty   = (cnt == '0);
    assign level   = cnt;
    assign rd_data = mem[rd_ptr];

    // Fullness is judged on the registered count, so a pop in a full
    // cycle never makes room for that same cycle's push.
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    // Storage write; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CNT_ONE;
                2'b01:   cnt <= cnt - CNT_ONE;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/capture_event_fifo.sv
// Tags capture events with the cycle delta since the previous record and
// queues them for the host. Also emits a timeout record when the delta
// counter saturates so elapsed time is never lost to wraparound.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | not capturing; delta held at 0, nothing written
//   ST_ARMED | delta counting; events/timeouts produce records
module capture_event_fifo
    import capture_pkg::*;
#(
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = 16,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  arm_start,
    input  logic                  arm_stop,
    input  logic                  flush,
    capture_event_fifo_if.slave   bus,
    output logic                  armed,
    output logic                  overflow
);
    localparam int REC_W  = rec_width(TS_W, DATA_W);
    localparam int D_LSB  = delta_lsb(DATA_W);
    localparam int F_BIT  = flag_bit(TS_W, DATA_W);
    localparam logic [TS_W-1:0] DELTA_MAX = '1;
    localparam logic [TS_W-1:0] DELTA_ONE = TS_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [TS_W-1:0]  delta;
    logic             rec_gen;
    logic [REC_W-1:0] rec;
    logic [REC_W-1:0] head;
    logic             fifo_full;
    logic             fifo_empty;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state: arm_stop wins over a coincident arm_start.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (arm_start && !arm_stop) state_nxt = ST_ARMED;
            ST_ARMED: if (arm_stop)               state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    assign armed = (state == ST_ARMED);

    // An event takes priority over a timeout; both carry the pre-clear delta.
    assign rec_gen = armed && (bus.cap_event || delta == DELTA_MAX);

    // Record formation from the package field layout.
    always_comb begin
        rec = '0;
        rec[DATA_LSB +: DATA_W] = bus.cap_data;
        rec[D_LSB +: TS_W]      = delta;
        rec[F_BIT]              = !bus.cap_event;
    end

    // Delta counter: restarts on every generated record, written or dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            delta <= '0;
        end else if (!armed || state_nxt == ST_IDLE || rec_gen) begin
            delta <= '0;
        end else begin
            delta <= delta + DELTA_ONE;
        end
    end

    // Sticky drop indicator; flush acknowledges it.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            overflow <= 1'b0;
        end else if (rec_gen && fifo_full) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rec_gen),
        .wr_data (rec),
        .pop     (bus.out_ready),
        .flush   (flush),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (bus.level)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_rec   = bus.out_valid ? head : '0;

endmodule

// File: tb/tb_capture_event_fifo.sv
// Directed bench for capture_event_fifo with TS_W=4 so timeouts are quick.
// Inputs change and outputs are sampled 1 ns after each rising edge.
module tb_capture_event_fifo;

    localparam int DATA_W = 16;
    localparam int TS_W   = 4;
    localparam int DEPTH  = 16;

    logic clk = 1'b0;
    logic rst;
    logic arm_start;
    logic arm_stop;
    logic flush;
    logic armed;
    logic overflow;

    int n_chk = 0;
    int n_err = 0;

    capture_event_fifo_if #(.DATA_W(DATA_W), .TS_W(TS_W), .DEPTH(DEPTH)) bus ();

    capture_event_fifo #(
        .TS_W   (TS_W),
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .arm_start (arm_start),
        .arm_stop  (arm_stop),
        .flush     (flush),
        .bus       (bus.slave),
        .armed     (armed),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic pulse_arm();
        arm_start = 1'b1;
        step();
        arm_start = 1'b0;
    endtask

    task automatic pulse_event(input logic [15:0] d);
        bus.cap_event = 1'b1;
        bus.cap_data  = d;
        step();
        bus.cap_event = 1'b0;
    endtask

    function automatic logic [31:0] mk_rec(input logic f, input logic [3:0] dl, input logic [15:0] d);
        return {11'd0, f, dl, d};
    endfunction

    initial begin
        rst           = 1'b1;
        arm_start     = 1'b0;
        arm_stop      = 1'b0;
        flush         = 1'b0;
        bus.cap_event = 1'b0;
        bus.cap_data  = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // First record: arm at edge k, event at k+4 sees delta 3.
        pulse_arm();
        chk("t1_armed", 32'(armed), 32'd1);
        step();
        step();
        step();
        chk("t1_pre_valid", 32'(bus.out_valid), 32'd0);
        pulse_event(16'hA5A5);
        chk("t1_valid", 32'(bus.out_valid), 32'd1);
        chk("t1_level", 32'(bus.level), 32'd1);
        chk("t1_rec", 32'(bus.out_rec), mk_rec(1'b0, 4'd3, 16'hA5A5));

        // Two events with ten idle edges between them; reader always ready.
        do_reset();
        bus.out_ready = 1'b1;
        pulse_arm();
        step();
        pulse_event(16'h1111);
        chk("t2_rec0", 32'(bus.out_rec), mk_rec(1'b0, 4'd1, 16'h1111));
        for (int i = 0; i < 10; i++) step();
        chk("t2_mid_level", 32'(bus.level), 32'd0);
        pulse_event(16'h2222);
        chk("t2_rec1", 32'(bus.out_rec), mk_rec(1'b0, 4'd10, 16'h2222));
        chk("t2_level1", 32'(bus.level), 32'd1);
        step();
        chk("t2_level0", 32'(bus.level), 32'd0);
        chk("t2_valid0", 32'(bus.out_valid), 32'd0);

        // Timeout after 15 silent cycles, then an event landing on delta 15.
        do_reset();
        bus.out_ready = 1'b0;
        pulse_arm();
        for (int i = 0; i < 15; i++) step();
        chk("t3_pre_level", 32'(bus.level), 32'd0);
        bus.cap_data = 16'h3C3C;
        step();
        chk("t3_to_level", 32'(bus.level), 32'd1);
        chk("t3_to_rec", 32'(bus.out_rec), mk_rec(1'b1, 4'd15, 16'h3C3C));
        for (int i = 0; i < 15; i++) step();
        chk("t3_restart_level", 32'(bus.level), 32'd1);
        pulse_event(16'h5A5A);
        chk("t3_ev_level", 32'(bus.level), 32'd2);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("t3_ev_rec", 32'(bus.out_rec), mk_rec(1'b0, 4'd15, 16'h5A5A));
        chk("t3_ev_level1", 32'(bus.level), 32'd1);

        // Fill past capacity with back-to-back events (delta 0 each).
        do_reset();
        pulse_arm();
        for (int i = 0; i < 17; i++) pulse_event(16'h1000 + 16'(i));
        chk("t4_full_level", 32'(bus.level), 32'd16);
        chk("t4_full_ovf", 32'(overflow), 32'd1);
        chk("t4_head0", 32'(bus.out_rec), mk_rec(1'b0, 4'd0, 16'h1000));
        // Pop and event together while full: pop happens, event is dropped.
        bus.out_ready = 1'b1;
        pulse_event(16'hBEEF);
        bus.out_ready = 1'b0;
        chk("t4_popev_level", 32'(bus.level), 32'd15);
        chk("t4_popev_ovf", 32'(overflow), 32'd1);
        arm_stop = 1'b1;
        step();
        arm_stop = 1'b0;
        chk("t4_stopped", 32'(armed), 32'd0);
        chk("t4_keep_level", 32'(bus.level), 32'd15);
        bus.out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            chk($sformatf("t4_drain%0d", i), 32'(bus.out_rec),
                mk_rec(1'b0, 4'd0, 16'h1000 + 16'(i)));
            step();
        end
        bus.out_ready = 1'b0;
        chk("t4_drained_level", 32'(bus.level), 32'd0);
        chk("t4_drained_valid", 32'(bus.out_valid), 32'd0);

        // Flush with a coincident event: everything discarded, overflow cleared.
        pulse_arm();
        for (int i = 0; i < 3; i++) pulse_event(16'h7000 + 16'(i));
        chk("t4_refill_level", 32'(bus.level), 32'd3);
        chk("t4_refill_ovf", 32'(overflow), 32'd1);
        flush = 1'b1;
        pulse_event(16'h7777);
        flush = 1'b0;
        chk("t4_flush_level", 32'(bus.level), 32'd0);
        chk("t4_flush_ovf", 32'(overflow), 32'd0);
        chk("t4_flush_valid", 32'(bus.out_valid), 32'd0);
        chk("t4_flush_armed", 32'(armed), 32'd1);

        // Coincident arm_start/arm_stop resolves to IDLE.
        do_reset();
        arm_start = 1'b1;
        arm_stop  = 1'b1;
        step();
        arm_start = 1'b0;
        arm_stop  = 1'b0;
        chk("t5_idle_both", 32'(armed), 32'd0);
        pulse_event(16'h1234);
        chk("t5_no_rec", 32'(bus.level), 32'd0);
        pulse_arm();
        chk("t5_armed", 32'(armed), 32'd1);
        arm_start = 1'b1;
        arm_stop  = 1'b1;
        step();
        arm_start = 1'b0;
        arm_stop  = 1'b0;
        chk("t5_armed_both", 32'(armed), 32'd0);

        // Reset with records queued discards them.
        do_reset();
        pulse_arm();
        for (int i = 0; i < 5; i++) pulse_event(16'h0040 + 16'(i));
        chk("t6_level5", 32'(bus.level), 32'd5);
        do_reset();
        chk("t6_level0", 32'(bus.level), 32'd0);
        chk("t6_valid0", 32'(bus.out_valid), 32'd0);
        chk("t6_armed0", 32'(armed), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
